// File: rtl/count_stream_checker.sv
// count_stream_checker: lock/error monitor for a stop-gated wrapping counter with decode flag.
// Define CNT_CHK_WRAP_EN to build the saturating wrap counter; otherwise wrap_cnt is tied to 0.
module count_stream_checker #(
  parameter int WIDTH      = 3,
  parameter int DECODE_VAL = 2,
  parameter int LOCK_CNT   = 2,
  parameter int ERR_LIMIT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             dec_in,
  input  logic             stop_in,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic             fault,
  output logic [7:0]       wrap_cnt
);
  typedef enum logic [1:0] {IDLE, ACQ, LOCK, FAULT} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic             r_prev_stop;
  logic [2:0]       r_good;
  logic [2:0]       r_err;
  logic [WIDTH-1:0] w_exp;
  logic             w_match;
  assign w_exp   = r_prev_stop ? r_prev : r_prev + 1'b1;
  assign w_match = (cnt_in == w_exp) && (dec_in == (cnt_in == WIDTH'(DECODE_VAL)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prev      <= '0;
      r_prev_stop <= 1'b0;
      r_good      <= '0;
      r_err       <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_sticky  <= 1'b0;
      fault       <= 1'b0;
    end else begin
      // FAULT freezes the prediction so the captured context survives for debug
      if (r_state != FAULT) begin
        r_prev      <= cnt_in;
        r_prev_stop <= stop_in;
      end
      err_pulse <= 1'b0;
      if (clr) begin
        r_state    <= IDLE;
        r_good     <= '0;
        r_err      <= '0;
        locked     <= 1'b0;
        err_sticky <= 1'b0;
        fault      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= ACQ;
            r_good  <= '0;
          end
          ACQ: begin
            if (!w_match) r_good <= '0;
            else if (r_good + 3'd1 == 3'(LOCK_CNT)) begin
              r_state <= LOCK;
              r_err   <= '0;
              locked  <= 1'b1;
            end else r_good <= r_good + 3'd1;
          end
          LOCK: begin
            if (!w_match) begin
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              r_err      <= r_err + 3'd1;
              if (r_err + 3'd1 == 3'(ERR_LIMIT)) begin
                r_state <= FAULT;
                locked  <= 1'b0;
                fault   <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
`ifdef CNT_CHK_WRAP_EN
  logic [7:0] r_wrap;
  logic       w_wrap;
  assign w_wrap = (r_prev == '1) && !r_prev_stop && (cnt_in == '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wrap <= '0;
    else if (clr) r_wrap <= '0;
    else if (r_state == LOCK && w_match && w_wrap && r_wrap != 8'hff) r_wrap <= r_wrap + 8'd1;
  end
  assign wrap_cnt = r_wrap;
`else
  assign wrap_cnt = '0;
`endif
endmodule

// File: tb/tb_count_stream_checker.sv
// tb_count_stream_checker: directed plus randomized stream checked against a behavioural model.
module tb_count_stream_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cnt_in = '0;
  logic       dec_in = 1'b0;
  logic       stop_in = 1'b0;
  logic       clr = 1'b0;
  logic       locked, err_pulse, err_sticky, fault;
  logic [7:0] wrap_cnt;
  int n_vec = 0;
  int n_bad = 0;
  int m_mode, m_prev, m_pstop, m_good, m_err, m_wrap;
  bit m_locked, m_pulse, m_sticky, m_fault;
  count_stream_checker dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .dec_in(dec_in), .stop_in(stop_in), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky), .fault(fault), .wrap_cnt(wrap_cnt)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_pstop = 0; m_good = 0; m_err = 0; m_wrap = 0;
    m_locked = 0; m_pulse = 0; m_sticky = 0; m_fault = 0;
  endtask
  // modes: 0 idle, 1 acquiring, 2 locked, 3 fault
  task automatic model_step(input int c, input bit d, input bit s, input bit cl);
    int  e;
    bit  ok;
    int  old;
    old = m_mode;
    e = m_pstop ? m_prev : (m_prev + 1) % 8;
    ok = (c == e) && (d == (c == 2));
    m_pulse = 0;
    if (cl) begin
      m_mode = 0; m_good = 0; m_err = 0; m_wrap = 0;
      m_locked = 0; m_sticky = 0; m_fault = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_good = 0;
    end else if (m_mode == 1) begin
      if (!ok) m_good = 0;
      else begin
        m_good++;
        if (m_good == 2) begin m_mode = 2; m_err = 0; m_locked = 1; end
      end
    end else if (m_mode == 2) begin
      if (ok) begin
`ifdef CNT_CHK_WRAP_EN
        if (m_prev == 7 && !m_pstop && c == 0 && m_wrap < 255) m_wrap++;
`endif
      end else begin
        m_pulse = 1; m_sticky = 1; m_err++;
        if (m_err == 3) begin m_mode = 3; m_locked = 0; m_fault = 1; end
      end
    end
    if (old != 3) begin m_prev = c; m_pstop = s; end
  endtask
  task automatic check(input string tag);
    n_vec += 5;
    assert (locked === m_locked) else begin n_bad++; $error("FAIL %s locked got %0b exp %0b", tag, locked, m_locked); end
    assert (err_pulse === m_pulse) else begin n_bad++; $error("FAIL %s err_pulse got %0b exp %0b", tag, err_pulse, m_pulse); end
    assert (err_sticky === m_sticky) else begin n_bad++; $error("FAIL %s err_sticky got %0b exp %0b", tag, err_sticky, m_sticky); end
    assert (fault === m_fault) else begin n_bad++; $error("FAIL %s fault got %0b exp %0b", tag, fault, m_fault); end
    assert (wrap_cnt === 8'(m_wrap)) else begin n_bad++; $error("FAIL %s wrap_cnt got %0d exp %0d", tag, wrap_cnt, m_wrap); end
  endtask
  task automatic tick(input string tag, input int c, input bit d, input bit s, input bit cl);
    cnt_in = 3'(c); dec_in = d; stop_in = s; clr = cl;
    @(posedge clk);
    model_step(c, d, s, cl);
    #1 check(tag);
  endtask
  task automatic clean(input string tag, input int c, input bit s);
    tick(tag, c, c == 2, s, 1'b0);
  endtask
  initial begin
    int tc;
    bit s;
    int c;
    bit d;
    model_reset();
    #2 check("reset");
    #10 rst = 1'b0;
    for (int i = 0; i <= 8; i++) clean("clean", i % 8, 1'b0);
    assert (locked === 1'b1) else begin n_bad++; $error("FAIL lock_after_stream locked got %0b exp 1", locked); end
    n_vec++;
    clean("run", 1, 1'b0);
    for (int i = 0; i < 5; i++) clean("stop2", 2, 1'b1);
    clean("go2", 2, 1'b0);
    tick("inject", 5, 0, 0, 0);
    clean("after6", 6, 1'b0);
    clean("after7", 7, 1'b1);
    clean("stop7", 7, 1'b1);
    clean("stop7b", 7, 1'b0);
    clean("wrap0", 0, 1'b1);
    clean("stop0", 0, 1'b0);
    tick("clr", 1, 0, 0, 1);
    for (int i = 2; i <= 7; i++) clean("relock", i, 1'b0);
    for (int k = 0; k < 3; k++) begin
      clean("dec_pre0", 0, 1'b0);
      clean("dec_pre1", 1, 1'b0);
      tick("dec_err", 2, 0, 0, 0);
      clean("dec_post", 3, 1'b0);
    end
    for (int i = 0; i < 4; i++) tick("fault_hold", (i * 3) % 8, i[0], 0, 0);
    tick("clr_fault", 6, 1, 0, 1);
    for (int i = 0; i < 3; i++) clean("relock2", i + 4, 1'b0);
    assert (locked === 1'b1) else begin n_bad++; $error("FAIL relock_after_clr locked got %0b exp 1", locked); end
    n_vec++;
    #3 rst = 1'b1;
    #1 model_reset();
    check("async_rst");
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) clean("relock3", i, 1'b0);
    tc = 3;
    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(3) == 0);
      c = tc;
      d = (c == 2);
      if ($urandom_range(11) == 0) c = (c + 1 + $urandom_range(6)) % 8;
      if ($urandom_range(15) == 0) d = ~d;
      tick("rand", c, d, s, $urandom_range(49) == 0);
      tc = s ? c : (c + 1) % 8;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
